riscv_imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the decode pipeline, supporting XLEN=32 or 64. It decodes the format and sign-extended immediate of each instruction and precomputes the PC-relative target. Results are delivered on a valid/ready interface through a 2-entry skid buffer, so back-pressure from execute does not cost throughput. Flush support drops wrong-path instructions on a taken branch or jump.

---
 rtl/riscv_imm_gen_stage.sv | 76 +++++++
 tb/tb_riscv_imm_gen_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/riscv_imm_gen_stage.sv
// riscv_imm_gen_stage: registered RISC-V immediate decode + pc-relative target, valid/ready with 2-entry skid (in: clk rst flush in_valid/in_ready in_inst in_pc; out: out_valid/out_ready out_inst out_pc out_imm out_fmt out_target)
module riscv_imm_gen_stage #(
  parameter int XLEN = 32,
  parameter bit RV64_OPS = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target
);
  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_Z = 3'd6;
  localparam int W = 35 + 3 * XLEN;
  localparam bit OP32 = RV64_OPS && (XLEN == 64);
  logic [6:0] op;
  logic [2:0] fmt;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm, target;
  logic [W-1:0] in_d, m_q, s_q;
  logic main_valid, skid_valid, accept;
  assign op = in_inst[6:0];
  always_comb begin
    fmt = (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 ||
           (op == 7'b1110011 && !in_inst[14]) || (OP32 && op == 7'b0011011)) ? F_I :
          op == 7'b0100011 ? F_S :
          op == 7'b1100011 ? F_B :
          (op == 7'b0110111 || op == 7'b0010111) ? F_U :
          op == 7'b1101111 ? F_J :
          op == 7'b1110011 ? F_Z : F_NONE;
    imm32 = fmt == F_I ? {{20{in_inst[31]}}, in_inst[31:20]} :
            fmt == F_S ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
            fmt == F_B ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
            fmt == F_U ? {in_inst[31:12], 12'b0} :
            fmt == F_J ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
            fmt == F_Z ? {27'b0, in_inst[19:15]} : 32'b0;
    imm = XLEN'($signed(imm32));
    target = in_pc + imm;
  end
  assign in_d = {in_inst, in_pc, imm, fmt, target};
  assign accept = in_valid && in_ready;
  assign in_ready = !skid_valid;
  assign out_valid = main_valid;
  assign {out_inst, out_pc, out_imm, out_fmt, out_target} = m_q;
  // skid_valid implies main_valid, so the skid branch only runs on a consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      m_q <= '0;
      s_q <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_valid && !out_ready) begin
      if (accept) begin
        skid_valid <= 1'b1;
        s_q <= in_d;
      end
    end else if (skid_valid) begin
      m_q <= s_q;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= accept;
      if (accept) m_q <= in_d;
    end
  end
endmodule

// File: tb/tb_riscv_imm_gen_stage.sv
// tb_riscv_imm_gen_stage: checks 64-bit and 32-bit instances against a queue-based reference model
module tb_riscv_imm_gen_stage;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_inst = 0;
  logic [63:0] in_pc = 0;
  logic r64, v64, r32, v32;
  logic [31:0] i64, i32;
  logic [63:0] p64, m64, t64;
  logic [31:0] p32, m32, t32;
  logic [2:0] f64, f32;
  int vecs = 0, misc = 0;
  typedef struct { logic [31:0] inst; logic [63:0] pc; } item_t;
  item_t q[$];
  always #5 clk = ~clk;
  riscv_imm_gen_stage #(.XLEN(64), .RV64_OPS(1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
    .out_inst(i64), .out_pc(p64), .out_imm(m64), .out_fmt(f64), .out_target(t64));
  riscv_imm_gen_stage #(.XLEN(32), .RV64_OPS(1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
    .out_inst(i32), .out_pc(p32), .out_imm(m32), .out_fmt(f32), .out_target(t32));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      misc++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void ref_dec(input logic [31:0] i, input logic [63:0] pc, input bit x64,
                                  output logic [2:0] f, output logic [63:0] imm, output logic [63:0] tgt);
    longint v;
    v = 0;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: begin f = 1; v = $signed(i[31:20]); end
      7'h23: begin f = 2; v = $signed({i[31:25], i[11:7]}); end
      7'h63: begin f = 3; v = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0}); end
      7'h6F: begin f = 5; v = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0}); end
      7'h37, 7'h17: begin f = 4; v = $signed({i[31:12], 12'b0}); end
      7'h73: if (i[14]) begin f = 6; v = longint'(i[19:15]); end else begin f = 1; v = $signed(i[31:20]); end
      7'h1B: begin f = x64 ? 3'd1 : 3'd0; v = x64 ? longint'($signed(i[31:20])) : 0; end
      default: f = 0;
    endcase
    imm = 64'(v);
    tgt = pc + 64'(v);
    if (!x64) begin
      imm = imm & 64'hFFFF_FFFF;
      tgt = tgt & 64'hFFFF_FFFF;
    end
  endfunction
  task automatic check_out();
    logic [2:0] f;
    logic [63:0] im, tg;
    chk("valid64", 64'(v64), 64'(q.size() != 0));
    chk("valid32", 64'(v32), 64'(q.size() != 0));
    if (q.size() != 0) begin
      ref_dec(q[0].inst, q[0].pc, 1'b1, f, im, tg);
      chk("inst64", 64'(i64), 64'(q[0].inst));
      chk("pc64", p64, q[0].pc);
      chk("imm64", m64, im);
      chk("fmt64", 64'(f64), 64'(f));
      chk("tgt64", t64, tg);
      ref_dec(q[0].inst, q[0].pc, 1'b0, f, im, tg);
      chk("inst32", 64'(i32), 64'(q[0].inst));
      chk("pc32", 64'(p32), 64'(q[0].pc[31:0]));
      chk("imm32", 64'(m32), im);
      chk("fmt32", 64'(f32), 64'(f));
      chk("tgt32", 64'(t32), tg);
    end
  endtask
  task automatic step(input bit v, input logic [31:0] inst, input logic [63:0] pc, input bit rdy, input bit fl);
    bit acc, cons;
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = rdy; flush = fl;
    #1;
    chk("in_ready64", 64'(r64), 64'(q.size() < 2));
    chk("in_ready32", 64'(r32), 64'(q.size() < 2));
    acc = v && q.size() < 2;
    cons = rdy && q.size() > 0;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back('{inst, pc});
    end
    check_out();
  endtask
  initial begin
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h1B, 7'h7F, 7'h33};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid64", 64'(v64), 0);
    chk("rst_imm64", m64, 0);
    chk("rst_tgt64", t64, 0);
    chk("rst_ready64", 64'(r64), 1);
    chk("rst_ready32", 64'(r32), 1);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    step(1, 32'h800000B7, 64'h1000, 1, 0);
    chk("lui_fmt64", 64'(f64), 4);
    chk("lui_imm64", m64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_tgt64", t64, 64'hFFFF_FFFF_8000_1000);
    step(1, 32'hFE000EE3, 64'h100, 1, 0);
    chk("beq_fmt32", 64'(f32), 3);
    chk("beq_imm32", 64'(m32), 64'hFFFF_FFFC);
    chk("beq_tgt32", 64'(t32), 64'hFC);
    step(1, 32'h300FD073, 64'h200, 1, 0);
    chk("csrrwi_fmt", 64'(f64), 6);
    chk("csrrwi_imm", m64, 64'h1F);
    step(1, 32'h0000007F, 64'h204, 1, 0);
    chk("none_fmt", 64'(f64), 0);
    chk("none_imm", m64, 0);
    step(1, 32'hFFC00093, 64'h2, 1, 0);
    chk("wrap_tgt32", 64'(t32), 64'hFFFF_FFFE);
    step(0, 0, 0, 1, 0);
    step(1, 32'h00500093, 64'h300, 0, 0);
    step(1, 32'h00A12023, 64'h304, 0, 0);
    step(1, 32'h008000EF, 64'h308, 0, 0);
    chk("abc_stall", 64'(r64), 0);
    step(1, 32'h008000EF, 64'h308, 1, 0);
    step(1, 32'h008000EF, 64'h308, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h00100113, 64'h400, 0, 0);
    step(1, 32'h00200193, 64'h404, 0, 0);
    step(1, 32'h12345037, 64'h408, 1, 1);
    chk("flush_valid", 64'(v64), 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h00300213, 64'h500, 0, 0);
    step(1, 32'hFFF00293, 64'h504, 0, 0);
    in_valid = 0;
    #3 rst = 1;
    #1;
    chk("arst_valid64", 64'(v64), 0);
    chk("arst_imm64", m64, 0);
    chk("arst_tgt64", t64, 0);
    chk("arst_valid32", 64'(v32), 0);
    chk("arst_tgt32", 64'(t32), 0);
    chk("arst_ready64", 64'(r64), 1);
    q.delete();
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    repeat (400) begin
      r = $urandom();
      step(($urandom() % 4) != 0, {r[31:7], ops[$urandom_range(0, 11)]},
           {$urandom(), $urandom()}, ($urandom() % 3) != 0, ($urandom() % 16) == 0);
    end
    repeat (3) step(0, 0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misc);
    $finish;
  end
endmodule
